flush_controller: RTL and testbench

FLUSH_CONTROLLER -- requirements
Module: flush_controller

---
 rtl/flush_controller.sv | 172 +++++++++++++++++
 tb/tb_flush_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flush_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flush_controller: arbitrates trap / fence.i / branch-miss redirects,       |
// | sequences I-cache invalidate and the one-cycle pipeline flush.             |
// | Optional FLUSH_PERF_COUNTER_EN adds a saturating flush-cycle counter.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module flush_controller #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INV_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trapReq,
   input  logic [ADDR_WIDTH-1:0] trapPc,
   input  logic                  fenceReq,
   input  logic [ADDR_WIDTH-1:0] fencePc,
   input  logic                  branchMissReq,
   input  logic [ADDR_WIDTH-1:0] branchMissPc,
   input  logic                  exStallReq,
   input  logic                  maStallReq,
   input  logic                  invDone,
   input  logic                  commitValid,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] nextPc,
   output logic                  trapAck,
   output logic                  fenceAck,
   output logic                  branchMissAck,
   output logic                  ifStall,
   output logic                  idStall,
   output logic                  rrStall,
   output logic                  exStall,
   output logic                  bypassStall,
   output logic                  invReq,
   output logic                  invTimeout,
   output logic [63:0]           opCommitCount,
   output logic [31:0]           flushCount
);

   localparam int CNT_W = $clog2(INV_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(INV_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_INVALIDATE = 2'd1,
      ST_FLUSH      = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   target_q, target_d;
   logic [CNT_W-1:0]        inv_cnt_q, inv_cnt_d;
   logic                    inv_timeout_q, inv_timeout_d;
   logic [63:0]             commit_cnt_q;
   logic [CNT_W-1:0]        w_inv_cnt_inc;
   logic                    w_stall_any;

   assign w_inv_cnt_inc = inv_cnt_q + 1'b1;
   assign w_stall_any   = exStallReq | maStallReq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         target_q      <= '0;
         inv_cnt_q     <= '0;
         inv_timeout_q <= 1'b0;
         commit_cnt_q  <= 64'd0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         inv_cnt_q     <= inv_cnt_d;
         inv_timeout_q <= inv_timeout_d;
         if (commitValid)
            commit_cnt_q <= commit_cnt_q + 64'd1;
      end
   end

   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      inv_cnt_d     = '0;
      inv_timeout_d = inv_timeout_q;
      flush         = 1'b0;
      trapAck       = 1'b0;
      fenceAck      = 1'b0;
      branchMissAck = 1'b0;
      ifStall       = 1'b0;
      idStall       = 1'b0;
      rrStall       = 1'b0;
      exStall       = 1'b0;
      bypassStall   = 1'b0;
      invReq        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            exStall     = maStallReq;
            rrStall     = w_stall_any;
            idStall     = w_stall_any;
            ifStall     = w_stall_any;
            bypassStall = w_stall_any;
            if (trapReq) begin
               trapAck  = 1'b1;
               target_d = trapPc;
               state_d  = ST_FLUSH;
            end else if (fenceReq) begin
               fenceAck = 1'b1;
               target_d = fencePc;
               state_d  = ST_INVALIDATE;
            end else if (branchMissReq) begin
               branchMissAck = 1'b1;
               target_d      = branchMissPc;
               state_d       = ST_FLUSH;
            end
         end
         ST_INVALIDATE: begin
            invReq      = 1'b1;
            ifStall     = 1'b1;
            idStall     = 1'b1;
            rrStall     = 1'b1;
            exStall     = 1'b1;
            bypassStall = 1'b1;
            inv_cnt_d   = w_inv_cnt_inc;
            // A completion arriving on the final counted cycle is not a timeout.
            if (invDone) begin
               state_d = ST_FLUSH;
            end else if (w_inv_cnt_inc == C_TIMEOUT) begin
               state_d       = ST_FLUSH;
               inv_timeout_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset is asynchronous, so combinational outputs are silenced immediately too.
      if (rst) begin
         flush         = 1'b0;
         trapAck       = 1'b0;
         fenceAck      = 1'b0;
         branchMissAck = 1'b0;
         ifStall       = 1'b0;
         idStall       = 1'b0;
         rrStall       = 1'b0;
         exStall       = 1'b0;
         bypassStall   = 1'b0;
         invReq        = 1'b0;
      end
   end

   assign nextPc        = target_q;
   assign invTimeout    = inv_timeout_q;
   assign opCommitCount = commit_cnt_q;

`ifdef FLUSH_PERF_COUNTER_EN
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flush_cnt_q <= 32'd0;
      else if ((state_q == ST_FLUSH) && (flush_cnt_q != 32'hFFFF_FFFF))
         flush_cnt_q <= flush_cnt_q + 32'd1;
   end

   assign flushCount = flush_cnt_q;
`else
   assign flushCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flush_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_flush_controller: self-checking bench for flush_controller.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_flush_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        trapReq, fenceReq, branchMissReq;
   logic [31:0] trapPc, fencePc, branchMissPc;
   logic        exStallReq, maStallReq, invDone, commitValid;
   logic        flush, trapAck, fenceAck, branchMissAck;
   logic        ifStall, idStall, rrStall, exStall, bypassStall;
   logic        invReq, invTimeout;
   logic [31:0] nextPc, flushCount;
   logic [63:0] opCommitCount;

   int          n_checks = 0;
   int          n_errors = 0;
   int          flush_events = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   flush_controller #(.ADDR_WIDTH(32), .INV_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .trapReq(trapReq), .trapPc(trapPc),
      .fenceReq(fenceReq), .fencePc(fencePc),
      .branchMissReq(branchMissReq), .branchMissPc(branchMissPc),
      .exStallReq(exStallReq), .maStallReq(maStallReq),
      .invDone(invDone), .commitValid(commitValid),
      .flush(flush), .nextPc(nextPc),
      .trapAck(trapAck), .fenceAck(fenceAck), .branchMissAck(branchMissAck),
      .ifStall(ifStall), .idStall(idStall), .rrStall(rrStall),
      .exStall(exStall), .bypassStall(bypassStall),
      .invReq(invReq), .invTimeout(invTimeout),
      .opCommitCount(opCommitCount), .flushCount(flushCount)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] stalls();
      return {ifStall, idStall, rrStall, exStall, bypassStall};
   endfunction

   function automatic logic [2:0] acks();
      return {trapAck, fenceAck, branchMissAck};
   endfunction

   // Scoreboard: every flush must match the oldest granted target.
   always @(negedge clk) begin
      if (!rst && flush) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_flush", {63'd0, flush}, 64'd0);
         end else begin
            chk("flush_nextPc", {32'd0, nextPc}, {32'd0, exp_q.pop_front()});
            flush_events++;
         end
      end
   end

   typedef struct {
      logic       ex;
      logic       ma;
      logic [4:0] st;   // {if,id,rr,ex,bypass}
   } vec_t;
   vec_t vecs[4];

   initial begin
      vecs[0] = '{ex: 1'b0, ma: 1'b0, st: 5'b00000};
      vecs[1] = '{ex: 1'b1, ma: 1'b0, st: 5'b11101};
      vecs[2] = '{ex: 1'b0, ma: 1'b1, st: 5'b11111};
      vecs[3] = '{ex: 1'b1, ma: 1'b1, st: 5'b11111};

      rst = 1'b1;
      trapReq = 0; fenceReq = 0; branchMissReq = 0;
      trapPc = 0; fencePc = 0; branchMissPc = 0;
      exStallReq = 0; maStallReq = 0; invDone = 0; commitValid = 0;
      #2;
      chk("rst_flush", {63'd0, flush}, 64'd0);
      chk("rst_acks", {61'd0, acks()}, 64'd0);
      chk("rst_stalls", {59'd0, stalls()}, 64'd0);
      chk("rst_invReq", {63'd0, invReq}, 64'd0);
      chk("rst_invTimeout", {63'd0, invTimeout}, 64'd0);
      chk("rst_nextPc", {32'd0, nextPc}, 64'd0);
      chk("rst_commit", opCommitCount, 64'd0);
      chk("rst_flushCount", {32'd0, flushCount}, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // Single trap redirect
      trapReq = 1; trapPc = 32'h8000_0100; exp_q.push_back(32'h8000_0100);
      #1 chk("t1_acks", {61'd0, acks()}, 64'b100);
      chk("t1_grant_noflush", {63'd0, flush}, 64'd0);
      @(negedge clk); trapReq = 0;
      #1 chk("t1_flush", {63'd0, flush}, 64'd1);
      chk("t1_flush_stalls", {59'd0, stalls()}, 64'd0);
      @(negedge clk);
      #1 chk("t1_flush_low", {63'd0, flush}, 64'd0);
      chk("t1_nextPc_hold", {32'd0, nextPc}, 64'h8000_0100);

      // All three requests together: trap, then fence, then branch miss
      @(negedge clk);
      trapReq = 1; fenceReq = 1; branchMissReq = 1;
      trapPc = 32'h1000; fencePc = 32'h2000; branchMissPc = 32'h3000;
      exp_q.push_back(32'h1000);
      #1 chk("t2_trap_only", {61'd0, acks()}, 64'b100);
      @(negedge clk); trapReq = 0;
      #1 chk("t2_ignored_in_flush", {61'd0, acks()}, 64'b000);
      @(negedge clk);
      #1 chk("t2_fence_grant", {61'd0, acks()}, 64'b010);
      exp_q.push_back(32'h2000);
      @(negedge clk); fenceReq = 0; invDone = 1;
      #1 chk("t2_invReq", {63'd0, invReq}, 64'd1);
      chk("t2_ignored_in_inv", {61'd0, acks()}, 64'b000);
      @(negedge clk); invDone = 0;
      #1 chk("t2_fence_flush", {63'd0, flush}, 64'd1);
      @(negedge clk);
      #1 chk("t2_bm_grant", {61'd0, acks()}, 64'b001);
      exp_q.push_back(32'h3000);
      @(negedge clk); branchMissReq = 0;
      #1 chk("t2_bm_flush", {63'd0, flush}, 64'd1);
      @(negedge clk);
      #1 chk("t2_nextPc_hold", {32'd0, nextPc}, 64'h3000);

      // Fence with invDone after 5 cycles
      @(negedge clk);
      fenceReq = 1; fencePc = 32'h200; exp_q.push_back(32'h200);
      #1 chk("t3_ack", {61'd0, acks()}, 64'b010);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); fenceReq = 0; invDone = (k == 5);
         #1 chk("t3_invReq", {63'd0, invReq}, 64'd1);
         chk("t3_stalls", {59'd0, stalls()}, 64'h1f);
      end
      @(negedge clk); invDone = 0;
      #1 chk("t3_flush", {63'd0, flush}, 64'd1);
      chk("t3_invReq_low", {63'd0, invReq}, 64'd0);
      chk("t3_noTimeout", {63'd0, invTimeout}, 64'd0);

      // Fence with no invDone: timeout after 8 cycles
      @(negedge clk);
      fenceReq = 1; fencePc = 32'h300; exp_q.push_back(32'h300);
      #1 chk("t4_ack", {61'd0, acks()}, 64'b010);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk); fenceReq = 0;
         #1 chk("t4_invReq", {63'd0, invReq}, 64'd1);
         chk("t4_timeout_pending", {63'd0, invTimeout}, 64'd0);
      end
      @(negedge clk);
      #1 chk("t4_flush", {63'd0, flush}, 64'd1);
      chk("t4_timeout_set", {63'd0, invTimeout}, 64'd1);
      @(negedge clk);
      #1 chk("t4_timeout_sticky", {63'd0, invTimeout}, 64'd1);

      // Stall mapping in IDLE
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); exStallReq = vecs[i].ex; maStallReq = vecs[i].ma;
         #1 chk($sformatf("stall_vec%0d", i), {59'd0, stalls()}, {59'd0, vecs[i].st});
      end

      // Grant takes precedence over a concurrent stall
      @(negedge clk);
      exStallReq = 0; maStallReq = 1; trapReq = 1; trapPc = 32'h4000;
      exp_q.push_back(32'h4000);
      #1 chk("t5_grant_ack", {61'd0, acks()}, 64'b100);
      chk("t5_grant_stalls", {59'd0, stalls()}, 64'h1f);
      @(negedge clk); trapReq = 0;
      #1 chk("t5_flush", {63'd0, flush}, 64'd1);
      chk("t5_flush_stalls", {59'd0, stalls()}, 64'd0);
      @(negedge clk); maStallReq = 0;
`ifdef FLUSH_PERF_COUNTER_EN
      #1 chk("flushCount", {32'd0, flushCount}, 64'(flush_events));
`else
      #1 chk("flushCount", {32'd0, flushCount}, 64'd0);
`endif

      // Commit counter wrap
      @(negedge clk);
      force dut.commit_cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
      commitValid = 1;
      #1 release dut.commit_cnt_q;
      chk("commit_preload", opCommitCount, 64'hFFFF_FFFF_FFFF_FFFE);
      repeat (3) @(negedge clk);
      commitValid = 0;
      #1 chk("commit_wrap", opCommitCount, 64'd1);

      // Reset mid-INVALIDATE abandons the flush
      @(negedge clk); fenceReq = 1; fencePc = 32'h500;
      @(negedge clk); fenceReq = 0;
      #1 chk("t6_in_inv", {63'd0, invReq}, 64'd1);
      @(negedge clk); rst = 1;
      #1 chk("t6_rst_invReq", {63'd0, invReq}, 64'd0);
      chk("t6_rst_stalls", {59'd0, stalls()}, 64'd0);
      chk("t6_rst_timeout", {63'd0, invTimeout}, 64'd0);
      chk("t6_rst_commit", opCommitCount, 64'd0);
      chk("t6_rst_nextPc", {32'd0, nextPc}, 64'd0);
      @(negedge clk); rst = 0;
      repeat (4) begin
         @(negedge clk);
         #1 chk("t6_no_flush", {63'd0, flush}, 64'd0);
         chk("t6_idle_invReq", {63'd0, invReq}, 64'd0);
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
